// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU definitions: opcode constants, the NOP word, the
//               fetch-stage state encoding, the PC reset vector and a PC
//               increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Opcode field [15:12] value for HLT
    localparam logic [3:0]  C_OP_HLT   = 4'hF;

    // Word loaded into IF/ID to form a bubble
    localparam logic [15:0] C_NOP_WORD = 16'h0000;

    // PC value after reset
    localparam logic [15:0] C_PC_RESET = 16'h0000;

    // Fetch-stage halt state machine
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HLT_SEEN = 2'd1,
        ST_HALTED   = 2'd2
    } fetch_state_e;

    // Byte-addressed sequential PC; wraps 0xFFFE -> 0x0000
    function automatic logic [15:0] pc_inc(input logic [15:0] pc);
        return pc + 16'd2;
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/if_id_pipe.sv
`default_nettype none
// ============================================================================
// Module      : if_id_pipe
// Description : IF/ID pipeline register. Holds, loads a bubble, or loads the
//               fetched instruction with its PC+2.
// Ports       : clk, rst_n        - clock, async active-low reset
//               i_hold            - keep current contents (priority)
//               i_bubble          - load NOP / pc_plus2 0 / valid 0
//               i_instr           - fetched instruction word
//               i_pc_plus2        - PC+2 of the fetched instruction
//               o_instr, o_pc_plus2, o_valid - registered outputs
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_pipe
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_hold,
    input  logic        i_bubble,
    input  logic [15:0] i_instr,
    input  logic [15:0] i_pc_plus2,
    output logic [15:0] o_instr,
    output logic [15:0] o_pc_plus2,
    output logic        o_valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_instr    <= C_NOP_WORD;
            o_pc_plus2 <= 16'h0000;
            o_valid    <= 1'b0;
        end else if (!i_hold) begin
            if (i_bubble) begin
                o_instr    <= C_NOP_WORD;
                o_pc_plus2 <= 16'h0000;
                o_valid    <= 1'b0;
            end else begin
                o_instr    <= i_instr;
                o_pc_plus2 <= i_pc_plus2;
                o_valid    <= 1'b1;
            end
        end
    end

endmodule : if_id_pipe
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage. Owns the PC, the HLT drain state
//               machine and its drain counter; drives the IF/ID register.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               stall                       - freeze PC and IF/ID
//               take_branch, branch_target  - redirect from ID
//               im_addr, im_rd_en, im_data  - instruction memory interface
//               instr_IF_ID, pc_plus2_IF_ID, valid_IF_ID - IF/ID outputs
//               halted                      - HLT fully drained
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        take_branch,
    input  logic [15:0] branch_target,
    output logic [15:0] im_addr,
    output logic        im_rd_en,
    input  logic [15:0] im_data,
    output logic [15:0] instr_IF_ID,
    output logic [15:0] pc_plus2_IF_ID,
    output logic        valid_IF_ID,
    output logic        halted
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [15:0]  r_pc;
    logic [1:0]   r_drain_cnt;

    logic         w_fetch;      // normal fetch this cycle
    logic         w_redirect;   // accepted branch redirect
    logic         w_drain;      // bubble cycle while draining a HLT
    logic         w_pipe_hold;
    logic         w_pipe_bubble;
    logic         w_is_hlt;

    assign w_is_hlt = (im_data[15:12] == C_OP_HLT);
    assign im_addr  = r_pc;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                // A HLT fetched in a redirect cycle is discarded
                if (!stall && !take_branch && w_is_hlt)
                    w_state_next = ST_HLT_SEEN;
            end
            ST_HLT_SEEN: begin
                if (!stall && (r_drain_cnt == 2'd3))
                    w_state_next = ST_HALTED;
            end
            ST_HALTED: w_state_next = ST_HALTED;
            default:   w_state_next = ST_RUN;
        endcase
    end

    // ---------------- output / control logic ----------------
    always_comb begin
        w_fetch    = 1'b0;
        w_redirect = 1'b0;
        w_drain    = 1'b0;
        im_rd_en   = 1'b0;
        halted     = 1'b0;
        case (r_state)
            ST_RUN: begin
                im_rd_en   = 1'b1;
                w_fetch    = !stall && !take_branch;
                w_redirect = !stall &&  take_branch;
            end
            ST_HLT_SEEN: w_drain = !stall;
            ST_HALTED:   halted  = 1'b1;
            default: ;
        endcase
        w_pipe_hold   = !(w_fetch || w_redirect || w_drain);
        w_pipe_bubble = w_redirect || w_drain;
    end

    // ---------------- PC ----------------
    // The PC freezes on the HLT fetch so it keeps pointing at the HLT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= C_PC_RESET;
        end else if (w_redirect) begin
            r_pc <= branch_target & 16'hFFFE;
        end else if (w_fetch && !w_is_hlt) begin
            r_pc <= pc_inc(r_pc);
        end
    end

    // ---------------- drain counter ----------------
    // Four bubble cycles follow the HLT; the wrap 3 -> 0 ends the drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain_cnt <= 2'd0;
        end else if (w_drain) begin
            r_drain_cnt <= r_drain_cnt + 2'd1;
        end
    end

    if_id_pipe u_if_id_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_hold     (w_pipe_hold),
        .i_bubble   (w_pipe_bubble),
        .i_instr    (im_data),
        .i_pc_plus2 (pc_inc(r_pc)),
        .o_instr    (instr_IF_ID),
        .o_pc_plus2 (pc_plus2_IF_ID),
        .o_valid    (valid_IF_ID)
    );

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage: directed scenarios then
//               randomized stall/redirect/reset traffic against a reference
//               model of the fetch rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        take_branch = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] im_addr;
    logic        im_rd_en;
    logic [15:0] im_data;
    logic [15:0] instr_IF_ID;
    logic [15:0] pc_plus2_IF_ID;
    logic        valid_IF_ID;
    logic        halted;

    logic [15:0] mem [0:32767];

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 = running, 1 = draining, 2 = halted
    logic [15:0] m_pc, m_instr, m_pp2;
    logic        m_valid;
    int          m_phase, m_drained;

    always #5 clk = ~clk;

    assign im_data = mem[im_addr[15:1]];

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .take_branch    (take_branch),
        .branch_target  (branch_target),
        .im_addr        (im_addr),
        .im_rd_en       (im_rd_en),
        .im_data        (im_data),
        .instr_IF_ID    (instr_IF_ID),
        .pc_plus2_IF_ID (pc_plus2_IF_ID),
        .valid_IF_ID    (valid_IF_ID),
        .halted         (halted)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_im_addr"},  im_addr,              m_pc);
        chk({tag, "_rd_en"},    {15'd0, im_rd_en},    {15'd0, m_phase == 0});
        chk({tag, "_halted"},   {15'd0, halted},      {15'd0, m_phase == 2});
        chk({tag, "_instr"},    instr_IF_ID,          m_instr);
        chk({tag, "_pc_plus2"}, pc_plus2_IF_ID,       m_pp2);
        chk({tag, "_valid"},    {15'd0, valid_IF_ID}, {15'd0, m_valid});
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = 16'h0000; m_pp2 = 16'h0000;
        m_valid = 1'b0; m_phase = 0; m_drained = 0;
    endtask

    task automatic model_step(input logic s, input logic b, input logic [15:0] t);
        logic [15:0] w;
        if (m_phase == 2 || s) return;
        if (m_phase == 1) begin
            m_instr = 16'h0000; m_pp2 = 16'h0000; m_valid = 1'b0;
            m_drained++;
            if (m_drained == 4) m_phase = 2;
        end else if (b) begin
            m_pc = {t[15:1], 1'b0};
            m_instr = 16'h0000; m_pp2 = 16'h0000; m_valid = 1'b0;
        end else begin
            w = mem[m_pc[15:1]];
            m_instr = w; m_pp2 = m_pc + 16'd2; m_valid = 1'b1;
            if (w[15:12] == 4'hF) begin
                m_phase = 1; m_drained = 0;
            end else begin
                m_pc = m_pc + 16'd2;
            end
        end
    endtask

    // Apply inputs mid-cycle, advance one rising edge, compare 1 time unit later
    task automatic cycle(input string tag, input logic s, input logic b, input logic [15:0] t);
        stall = s; take_branch = b; branch_target = t;
        model_step(s, b, t);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse entirely between clock edges
    task automatic do_reset(input string tag);
        stall = 1'b0; take_branch = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        check_all(tag);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom) & 16'hEFFF;
        mem[0]     = 16'h1123;
        mem[1]     = 16'h2345;
        mem[8]     = 16'hF000;   // HLT at 0x10
        mem[16'h12] = 16'hF123;  // HLT at 0x24

        #1;
        do_reset("reset");

        // Sequential fetch
        cycle("seq0", 0, 0, 0);
        chk("seq0_word", instr_IF_ID, 16'h1123);
        chk("seq0_pp2",  pc_plus2_IF_ID, 16'h0002);
        cycle("seq1", 0, 0, 0);
        chk("seq1_word", instr_IF_ID, 16'h2345);
        chk("seq1_pp2",  pc_plus2_IF_ID, 16'h0004);
        cycle("seq2", 0, 0, 0);
        chk("seq2_addr", im_addr, 16'h0006);

        // Stall for two cycles at PC=6
        cycle("stall0", 1, 0, 0);
        cycle("stall1", 1, 0, 0);
        chk("stall_addr", im_addr, 16'h0006);
        cycle("resume", 0, 0, 0);
        chk("resume_word", instr_IF_ID, mem[3]);

        // Redirect to odd target 0x41 -> 0x40
        cycle("redir", 0, 1, 16'h0041);
        chk("redir_addr", im_addr, 16'h0040);
        chk("redir_valid", {15'd0, valid_IF_ID}, 16'h0000);
        cycle("redir_fetch", 0, 0, 0);
        chk("redir_word", instr_IF_ID, mem[16'h20]);

        // Stall and branch together: branch ignored
        cycle("stall_br", 1, 1, 16'h0080);
        chk("stall_br_addr", im_addr, 16'h0042);

        // HLT at 0x10 drains through four bubbles then halts
        cycle("to_hlt", 0, 1, 16'h0010);
        cycle("hlt", 0, 0, 0);
        chk("hlt_word",  instr_IF_ID, 16'hF000);
        chk("hlt_rd_en", {15'd0, im_rd_en}, 16'h0000);
        for (int i = 0; i < 3; i++) cycle("drain", 0, 0, 0);
        chk("drain_not_halted", {15'd0, halted}, 16'h0000);
        cycle("drain_last", 0, 0, 0);
        chk("halted_set", {15'd0, halted}, 16'h0001);
        cycle("halted_br", 0, 1, 16'h0100);
        cycle("halted_st", 1, 0, 0);
        chk("halted_pc", im_addr, 16'h0010);

        // HLT fetched in a redirect cycle is flushed
        do_reset("reset2");
        cycle("to_hlt2", 0, 1, 16'h0010);
        cycle("flush_hlt", 0, 1, 16'h0020);
        chk("flush_rd_en", {15'd0, im_rd_en}, 16'h0001);
        chk("flush_addr", im_addr, 16'h0020);

        // Reset in the middle of a drain
        cycle("to_hlt3", 0, 1, 16'h0010);
        cycle("hlt3", 0, 0, 0);
        cycle("drain3", 0, 0, 0);
        do_reset("mid_drain_reset");
        cycle("after_reset", 0, 0, 0);
        chk("after_reset_word", instr_IF_ID, 16'h1123);

        // Randomized traffic
        for (int seg = 0; seg < 6; seg++) begin
            @(posedge clk); #1;
            do_reset("rnd_reset");
            for (int n = 0; n < 150; n++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 3) begin
                    do_reset("rnd_async_reset");
                end else begin
                    cycle("rnd", r < 28, $urandom_range(0, 99) < 20,
                          16'($urandom_range(0, 16'h0060)));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-003 SHALL have port stall, input, 1, load-use stall from ID hazard detection; freezes PC and IF/ID.
REQ-004 SHALL have port take_branch, input, 1, resolved redirect from ID (branch/JAL/JR).
REQ-005 SHALL have port branch_target, input, 16, redirect byte address.
REQ-006 SHALL have port im_addr, output, 16, instruction memory address, equal to the PC register.
REQ-007 SHALL have port im_rd_en, output, 1, instruction memory read enable.
REQ-008 SHALL have port im_data, input, 16, instruction word returned combinationally for im_addr.
REQ-009 SHALL have port instr_IF_ID, output, 16, registered instruction to decode.
REQ-010 SHALL have port pc_plus2_IF_ID, output, 16, registered PC+2 of that instruction (JAL link, branch base).
REQ-011 SHALL have port valid_IF_ID, output, 1, registered; 0 marks an inserted bubble.
REQ-012 SHALL have port halted, output, 1, high once HLT has drained; stays high until reset.

Function
REQ-013 SHALL keep the PC, byte addressed; PC+2 wraps 0xFFFE to 0x0000; branch_target bit 0 is forced to 0 on load.
REQ-014 SHALL use this per-cycle priority: halted state, then stall, then take_branch, then normal fetch.
REQ-015 On stall=1, SHALL hold the PC and all IF/ID outputs, and SHALL ignore take_branch that cycle.
REQ-016 On take_branch=1 with stall=0, SHALL load PC from branch_target and load IF/ID with NOP 0x0000, valid 0 and pc_plus2 0; the fetched word is discarded.
REQ-017 On normal fetch, SHALL load IF/ID with im_data, PC+2 and valid 1, and advance the PC by 2.
REQ-018 SHALL use states RUN, HLT_SEEN and HALTED.
REQ-019 In RUN, a normal fetch whose im_data[15:12]=4'hF SHALL latch the HLT into IF/ID, freeze the PC, and move to HLT_SEEN.
REQ-020 A HLT fetched in a take_branch cycle SHALL be discarded and the block SHALL stay in RUN.
REQ-021 In HLT_SEEN, each non-stall cycle SHALL load a NOP bubble and increment a 2-bit drain counter; the counter wrapping 3 to 0 SHALL move the block to HALTED.
REQ-022 Stall SHALL freeze the drain counter.
REQ-023 In HALTED, the PC and IF/ID SHALL hold, halted SHALL be 1, and stall/take_branch SHALL be ignored.
REQ-024 SHALL drive im_rd_en=1 only in RUN, and 0 in HLT_SEEN and HALTED.
REQ-025 Latency: an instruction at address A SHALL appear on instr_IF_ID one cycle after im_addr=A, absent stall or redirect.

Reset
REQ-026 While rst_n=0, SHALL force PC 0x0000, instr_IF_ID 0x0000, pc_plus2_IF_ID 0x0000, valid_IF_ID 0, drain counter 0, state RUN and halted 0, independent of clk.
REQ-027 SHALL fetch address 0x0000 on the first rising edge after rst_n rises.
REQ-028 Reset asserted in any state, including mid-drain or HALTED, SHALL fully abort that operation and return to the reset values.

Structure
REQ-029 SHALL take the following from the shared cpu package: opcode constants (HLT=4'hF), NOP word 16'h0000, the fetch state enum, and the PC reset vector.
REQ-030 SHALL implement the IF/ID register (hold, bubble-load, normal-load) as sub-module if_id_pipe; the PC, the halt state machine and the drain counter SHALL reside in fetch_stage.

Verification
REQ-031 Sequential fetch: memory words 0x1123,0x2345 at addr 0,2; after reset -> im_addr 0,2,4 on successive cycles; instr_IF_ID 0x1123 then 0x2345 with pc_plus2 2 then 4 and valid 1.
REQ-032 Stall: stall=1 for 2 cycles at PC=6 -> im_addr stays 6 and IF/ID is unchanged; on release, fetch resumes at 6.
REQ-033 Redirect: take_branch=1 with branch_target 0x0041 at PC=8 -> next im_addr 0x0040; IF/ID becomes 0x0000 with valid 0; the next cycle fetches the word at 0x40.
REQ-034 Stall plus branch in the same cycle -> redirect ignored and PC held.
REQ-035 HLT: word 0xF000 at 0x10 -> IF/ID gets 0xF000; im_rd_en goes 0 the same cycle; four bubbles follow; halted=1 on the 5th edge and stays 1; PC stays 0x10.
REQ-036 Flushed HLT and mid-drain reset: 0xF000 fetched with take_branch=1 -> state RUN and no halt; separately, rst_n pulsed low mid-drain -> every output returns to its reset value immediately.
